seg_scan_ctrl: RTL and testbench



---
 rtl/bike_disp_pkg.sv | 24 ++
 rtl/scan_prescaler.sv | 33 +++
 rtl/seg_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bike_disp_pkg.sv
// Shared definitions for the bike display scan path: digit-count default,
// BCD limit, all-off digit-select helper and the scan FSM encoding.
package bike_disp_pkg;

    localparam int         NUM_DIGITS_DEF = 4;
    localparam int         MAX_DIGITS     = 8;
    localparam logic [3:0] BCD_MAX        = 4'd9;

    typedef enum logic {
        OFF  = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    // All-ones select (every anode off) for an n-digit display, LSB aligned.
    function automatic logic [MAX_DIGITS-1:0] dig_off(input int n);
        logic [MAX_DIGITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1 while enabled and pulses tick_o
// on the last count; the count is held (not cleared) while disabled.
module scan_prescaler #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clock,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int               DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST  = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered BCD word.
// Optional build macro LEAD_ZERO_BLANK_EN blanks zero digits above the MSD.
module seg_scan_ctrl
    import bike_disp_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    output logic [3:0]              dig_bcd,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done
);

    localparam int                    IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = NUM_DIGITS'(dig_off(NUM_DIGITS));

    scan_state_e               state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0]   pend_q, pend_d;
    logic                      pend_vld_q, pend_vld_d;
    logic [3:0]                dig_bcd_q, dig_bcd_d;
    logic [NUM_DIGITS-1:0]     sel_p1_q, sel_p1_d;
    logic [NUM_DIGITS-1:0]     dig_sel_q, dig_sel_d;
    logic                      frame_done_q, frame_done_d;
    logic                      scan_en, tick, wrap, capture, transfer;
    logic [NUM_DIGITS-1:0]     show;

    assign scan_en = (state_q == SCAN);

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clock  (clock),
        .rst_n  (rst_n),
        .en_i   (scan_en),
        .tick_o (tick)
    );

`ifdef LEAD_ZERO_BLANK_EN
    // A digit is shown once any digit at or above it is nonzero; digit 0 always.
    logic seen;
    always_comb begin
        seen = 1'b0;
        show = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (disp_q[4*k +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            show[k] = seen || (k == 0);
        end
    end
`else
    assign show = '1;
`endif

    always_comb begin
        state_d = enable ? SCAN : OFF;
    end

    always_comb begin
        wrap  = tick && (idx_q == IDX_LAST);
        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end

        // The display buffer only moves at a frame boundary or while dark.
        capture    = upd_valid && !pend_vld_q;
        transfer   = pend_vld_q && (wrap || (state_q == OFF));
        disp_d     = transfer ? pend_q : disp_q;
        pend_d     = capture ? bcd_in : pend_q;
        pend_vld_d = pend_vld_q;
        if (transfer) begin
            pend_vld_d = 1'b0;
        end
        if (capture) begin
            pend_vld_d = 1'b1;
        end

        // Stage 1: code to decoder, select for the same slot held one clock back.
        dig_bcd_d = '0;
        sel_p1_d  = DIG_OFF;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                dig_bcd_d = disp_q[4*k +: 4];
                if ((disp_q[4*k +: 4] <= BCD_MAX) && show[k]) begin
                    sel_p1_d[k] = 1'b0;
                end
            end
        end

        // Stage 2: anode select lands with the decoder's registered segments.
        dig_sel_d    = (state_d == SCAN) ? sel_p1_q : DIG_OFF;
        frame_done_d = wrap;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            dig_bcd_q    <= '0;
            sel_p1_q     <= DIG_OFF;
            dig_sel_q    <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            dig_bcd_q    <= dig_bcd_d;
            sel_p1_q     <= sel_p1_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign upd_ready  = !pend_vld_q;
    assign dig_bcd    = dig_bcd_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=4); expected
// anode/code pairs are queued per directed phase and popped on each dig_sel change.
module tb_seg_scan_ctrl;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        upd_valid = 1'b0;
    logic [15:0] bcd_in = 16'h0;
    logic        upd_ready;
    logic [3:0]  dig_bcd;
    logic [3:0]  dig_sel;
    logic        frame_done;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  e;
    logic [3:0]  prev_sel = 4'hF;
    logic [3:0]  prev_bcd = 4'h0;

    seg_scan_ctrl #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .enable     (enable),
        .bcd_in     (bcd_in),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .dig_bcd    (dig_bcd),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] s, input logic [3:0] b);
        exp_q.push_back({s, b});
    endtask

    task automatic push_frame(input logic [15:0] v);
        push(4'b1110, v[3:0]);
        push(4'b1101, v[7:4]);
        push(4'b1011, v[11:8]);
        push(4'b0111, v[15:12]);
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_done && n < 100);
        if (!frame_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_timeout: no frame_done after %0d cycles", n);
        end
    endtask

    task automatic offer(input logic [15:0] v, output int waited, output logic fd);
        waited = 0;
        while (!upd_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        fd = frame_done;
        if (!upd_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: upd_ready low for %0d cycles", waited);
        end
        upd_valid = 1'b1;
        bcd_in    = v;
        @(negedge clock);
        upd_valid = 1'b0;
        bcd_in    = 16'hEEEE;
    endtask

    // Monitor: every anode change must match the next queued slot; the code
    // must already have been on dig_bcd one clock earlier.
    always @(negedge clock) begin
        if (!rst_n) begin
            prev_sel = 4'hF;
            prev_bcd = dig_bcd;
        end else begin
            if (dig_sel !== prev_sel) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got sel=%b bcd=%h, none expected", dig_sel, dig_bcd);
                end else begin
                    e = exp_q.pop_front();
                    if ({dig_sel, dig_bcd, prev_bcd} !== {e[7:4], e[3:0], e[3:0]}) begin
                        n_fail++;
                        $display("FAIL sb_slot: got sel=%b bcd=%h prev_bcd=%h, expected sel=%b bcd=%h",
                                 dig_sel, dig_bcd, prev_bcd, e[7:4], e[3:0]);
                    end
                end
            end
            prev_sel = dig_sel;
            prev_bcd = dig_bcd;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   w;
        logic fd;

        repeat (3) @(negedge clock);
        check("reset_dig_sel", dig_sel, 4'hF);
        check("reset_dig_bcd", dig_bcd, 4'h0);
        check("reset_frame_done", frame_done, 1'b0);
        check("reset_upd_ready", upd_ready, 1'b1);

`ifdef LEAD_ZERO_BLANK_EN
        push(4'b1110, 4'h0); push(4'b1111, 4'h0);
`else
        push_frame(16'h0000);
`endif
        push_frame(16'h1234);
        push_frame(16'h1234);
        push_frame(16'h1111);
        push_frame(16'h2222);
        push(4'b1110, 4'h8); push(4'b1101, 4'h7); push(4'b1011, 4'h6);
        push(4'b1111, 4'h6); push(4'b1011, 4'h6); push(4'b0111, 4'h5);
        push_frame(16'h5678);
        push(4'b1110, 4'h4); push(4'b1111, 4'hA); push(4'b1011, 4'h2); push(4'b0111, 4'h1);
`ifdef LEAD_ZERO_BLANK_EN
        push(4'b1110, 4'h0); push(4'b1101, 4'h5); push(4'b1111, 4'h0);
        push(4'b1110, 4'h0); push(4'b1111, 4'h0);
`else
        push_frame(16'h0050);
        push_frame(16'h0000);
`endif
        push(4'b1110, 4'h0);

        #2 rst_n = 1'b1;
        enable = 1'b1;

        // Plan 1: load 0x1234 mid-frame, applied at the next wrap.
        repeat (8) @(negedge clock);
        offer(16'h1234, w, fd);
        check("ready_drop_after_capture", upd_ready, 1'b0);
        wait_frame(n);
        check("ready_after_transfer", upd_ready, 1'b1);
        wait_frame(n);
        check("frame_period", n, 16);

        // Plan 2: back-to-back offers; the second waits for the wrap.
        offer(16'h1111, w, fd);
        check("ready_low_while_pending", upd_ready, 1'b0);
        offer(16'h2222, w, fd);
        check("ready_wait_cycles", w, 15);
        check("ready_at_wrap", fd, 1'b1);
        wait_frame(n);

        // Plan 3: drop enable during digit 2, then resume.
        offer(16'h5678, w, fd);
        wait_frame(n);
        repeat (10) @(negedge clock);
        check("digit2_before_off", dig_sel, 4'b1011);
        enable = 1'b0;
        @(negedge clock);
        check("off_next_clock", dig_sel, 4'b1111);
        repeat (5) @(negedge clock);
        check("off_held_sel", dig_sel, 4'b1111);
        check("off_index_frozen", dig_bcd, 4'h6);
        enable = 1'b1;
        @(negedge clock);
        check("resume_digit2", dig_sel, 4'b1011);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (dig_sel == 4'b1011 && n < 20);
        check("resume_slot_remaining", n, 3);
        wait_frame(n);

        // Plans 4/5: invalid-code blanking, then leading-zero cases.
        offer(16'h12A4, w, fd);
        wait_frame(n);
        offer(16'h0050, w, fd);
        wait_frame(n);
        offer(16'h0000, w, fd);
        wait_frame(n);
        wait_frame(n);

        // Plan 6: asynchronous reset mid-digit with an update pending.
        offer(16'h9999, w, fd);
        check("pending_before_reset", upd_ready, 1'b0);
        repeat (2) @(negedge clock);
        check("pre_reset_digit0", dig_sel, 4'b1110);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_dig_sel", dig_sel, 4'hF);
        check("async_reset_upd_ready", upd_ready, 1'b1);
        check("async_reset_dig_bcd", dig_bcd, 4'h0);
        check("async_reset_frame_done", frame_done, 1'b0);
        check("sb_drained_before_reset", exp_q.size(), 0);

`ifdef LEAD_ZERO_BLANK_EN
        push(4'b1110, 4'h0); push(4'b1111, 4'h0);
`else
        push_frame(16'h0000);
`endif
        push(4'b1110, 4'h0);

        repeat (3) @(negedge clock);
        #2 rst_n = 1'b1;
        @(negedge clock);
        check("restart_from_off", dig_sel, 4'hF);
        @(negedge clock);
        check("restart_digit0_sel", dig_sel, 4'b1110);
        check("restart_digit0_bcd", dig_bcd, 4'h0);
        wait_frame(n);
        repeat (4) @(negedge clock);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
